// File: rtl/pipe_cla_adder_if.sv
// ---------------------------------------------------------------------------
// pipe_cla_adder_if
//   Operand/result handshake bundle for pipe_cla_adder.
//   Optional feature macro: PIPE_ADDER_SUB_EN (adds the sub select).
//
//   Signals:
//     in_valid / in_ready     operand beat handshake
//     a, b [WIDTH]            operands
//     cin                     carry-in (borrow-in when subtracting)
//     sub                     subtract select (PIPE_ADDER_SUB_EN only)
//     out_valid / out_ready   result beat handshake
//     sum [WIDTH]             result
//     cout, ovf, zero         carry out, signed overflow, sum == 0
//
//   master: operand producer / result consumer.  slave: the adder.
// ---------------------------------------------------------------------------
interface pipe_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef PIPE_ADDER_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
`ifdef PIPE_ADDER_SUB_EN
    output sub,
`endif
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
`ifdef PIPE_ADDER_SUB_EN
    input  sub,
`endif
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/pipe_cla_adder.sv
// ---------------------------------------------------------------------------
// pipe_cla_adder
//   Pipelined carry-lookahead adder. A WIDTH-bit add is split into
//   NSEG = WIDTH/SEG segments; segment k is computed in stage k with a
//   flattened SEG-bit lookahead, and its carry-out is registered into
//   stage k+1. Upper operand bits ride forward in skew registers, finished
//   lower sum bits ride forward in deskew registers, so the whole result
//   lines up in the last stage. Latency is NSEG cycles, one beat per cycle.
//
//   Optional feature macro: PIPE_ADDER_SUB_EN
//     defined   : bus.sub selects a - b - cin (b inverted, carry-in inverted;
//                 cout = 1 means no borrow).
//     undefined : add only, no sub signal.
//
//   Parameters:
//     WIDTH  operand/result width, must be a multiple of SEG
//     SEG    segment width per stage, 1..8
//
//   Ports:
//     clk    clock, rising edge
//     rst_n  asynchronous active-low reset (clears valids and result regs)
//     bus    pipe_cla_adder_if.slave: operand and result handshakes
// ---------------------------------------------------------------------------

// One SEG-bit lookahead segment. Every internal carry is formed as a
// flat sum of products of the generate/propagate terms and the
// segment carry-in, so no ripple path exists inside the segment.
module pipe_cla_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);
  logic [SEG-1:0] p;
  logic [SEG-1:0] g;
  logic [SEG:0]   gc;   // gc[0] = ci, gc[j] = g[j-1]: the carry sources
  logic [SEG:0]   c;
  logic           term;

  assign p  = a ^ b;
  assign g  = a & b;
  assign gc = {g, ci};

  // c[i+1] = OR over sources j of gc[j] & p[j] & ... & p[i]
  always_comb begin
    c    = '0;
    term = 1'b0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      for (int j = 0; j <= i + 1; j++) begin
        term = gc[j];
        for (int m = j; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign s  = p ^ c[SEG-1:0];
  assign co = c[SEG];
endmodule

module pipe_cla_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  pipe_cla_adder_if.slave   bus
);
  localparam int NSEG   = WIDTH / SEG;
  localparam int STAGES = NSEG - 1;

  if (SEG < 1 || SEG > 8 || (WIDTH % SEG) != 0) begin : g_param_chk
    $error("pipe_cla_adder: SEG must be 1..8 and divide WIDTH");
  end

  logic              advance;
  logic [STAGES:0]   vld_pipe;   // vld_pipe[k] = stage k holds a beat
  logic [WIDTH-1:0]  b_eff;
  logic              cin_eff;
  logic [WIDTH-1:0]  sum_q;
  logic              cout_q;
  logic              ovf_q;
  logic              zero_q;

  // Subtract folds into the add: a + ~b + ~cin == a - b - cin.
`ifdef PIPE_ADDER_SUB_EN
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.cin ^ bus.sub;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  // Whole pipe moves as one; only a stalled valid result blocks it.
  assign advance       = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe <= '0;
    end else if (advance) begin
      vld_pipe[0] <= bus.in_valid;
      for (int k = 1; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  for (genvar k = 0; k < NSEG; k++) begin : stg
    localparam int LO = k * SEG;

    logic [WIDTH-LO-1:0] op_a;     // operand bits for segments k..NSEG-1
    logic [WIDTH-LO-1:0] op_b;
    logic                ci;
    logic                vin;      // a real beat is entering this stage
    logic [SEG-1:0]      s;
    logic                co;
    logic [LO+SEG-1:0]   s_full;   // sum bits 0 .. end of segment k

    if (k == 0) begin : src
      assign op_a   = bus.a;
      assign op_b   = b_eff;
      assign ci     = cin_eff;
      assign vin    = bus.in_valid;
      assign s_full = s;
    end else begin : src
      assign op_a   = stg[k-1].sk.a_q;
      assign op_b   = stg[k-1].sk.b_q;
      assign ci     = stg[k-1].sk.c_q;
      assign vin    = vld_pipe[k-1];
      assign s_full = {s, stg[k-1].sk.s_q};
    end

    pipe_cla_seg #(.SEG(SEG)) u_seg (
      .a  (op_a[SEG-1:0]),
      .b  (op_b[SEG-1:0]),
      .ci (ci),
      .s  (s),
      .co (co)
    );

    if (k < STAGES) begin : sk
      // Data regs are not reset: only the valid bits qualify them.
      // Loading only with a real beat keeps bubbles from toggling them.
      logic [WIDTH-LO-SEG-1:0] a_q;
      logic [WIDTH-LO-SEG-1:0] b_q;
      logic [LO+SEG-1:0]       s_q;
      logic                    c_q;

      always_ff @(posedge clk) begin
        if (advance && vin) begin
          a_q <= op_a[WIDTH-LO-1:SEG];
          b_q <= op_b[WIDTH-LO-1:SEG];
          s_q <= s_full;
          c_q <= co;
        end
      end
    end else begin : fin
      // Carry into the MSB recovered from the MSB sum bit, so the
      // segment adder need not expose its internal carries.
      logic c_msb;
      assign c_msb = op_a[SEG-1] ^ op_b[SEG-1] ^ s[SEG-1];

      // Result regs only change when a valid beat lands, so they hold
      // through stalls and bubbles.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (advance && vin) begin
          sum_q  <= s_full;
          cout_q <= co;
          ovf_q  <= co ^ c_msb;
          zero_q <= ~|s_full;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipe_cla_adder.sv
module tb_pipe_cla_adder;
  localparam int W    = 16;
  localparam int SEG  = 4;
  localparam int NSEG = W / SEG;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  logic sub_drv;
  int   checks = 0;
  int   errors = 0;

  // latency model: NSEG-deep delay line that freezes on a stalled output
  bit   mv [NSEG];
  res_t mr [NSEG];

  logic [W-1:0] dir_a [6] = '{16'h1234, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h8000};
  logic [W-1:0] dir_b [6] = '{16'h5678, 16'h5678, 16'hFFFF, 16'h0001, 16'h0001, 16'h8000};
  logic         dir_c [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  // {sum, cout, ovf, zero}
  res_t dir_exp [6] = '{{16'h68AC, 3'b000}, {16'h68AD, 3'b000}, {16'hFFFE, 3'b100},
                        {16'h0000, 3'b101}, {16'h8000, 3'b010}, {16'h0000, 3'b111}};

  pipe_cla_adder_if #(.WIDTH(W)) bus();

  pipe_cla_adder #(.WIDTH(W), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef PIPE_ADDER_SUB_EN
  assign bus.sub = sub_drv;
`endif

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Plain arithmetic reference: unsigned for sum/carry, signed for overflow.
  function automatic res_t ref_result(logic [W-1:0] a, logic [W-1:0] b, logic c, logic s);
    res_t   r;
    longint ua, ub, sa, sb, us, ss;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (s) begin
      us     = ua - ub - longint'(c);
      ss     = sa - sb - longint'(c);
      r.cout = (us >= 0);
    end else begin
      us     = ua + ub + longint'(c);
      ss     = sa + sb + longint'(c);
      r.cout = (us >= (longint'(1) << W));
    end
    r.sum  = us[W-1:0];
    r.ovf  = (ss > ((longint'(1) << (W-1)) - 1)) || (ss < -(longint'(1) << (W-1)));
    r.zero = (r.sum == '0);
    return r;
  endfunction

  function automatic res_t dut_res();
    return {bus.sum, bus.cout, bus.ovf, bus.zero};
  endfunction

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c, input logic s, input logic ordy);
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.cin       = c;
    sub_drv       = s;
    bus.out_ready = ordy;
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < NSEG; i++) begin
      mv[i] = 1'b0;
      mr[i] = '0;
    end
  endtask

  // Called just before the active edge, with the inputs for that edge driven.
  task automatic mdl_step();
    if (!mv[NSEG-1] || bus.out_ready) begin
      for (int i = NSEG - 1; i > 0; i--) begin
        mv[i] = mv[i-1];
        mr[i] = mr[i-1];
      end
      mv[0] = bus.in_valid;
      mr[0] = ref_result(bus.a, bus.b, bus.cin, sub_drv);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    mdl_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum: got %h expected 0000", bus.sum); end
    checks++; if (bus.cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b expected 0", bus.cout); end
    checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.ovf); end
    checks++; if (bus.zero !== 1'b0) begin errors++; $display("FAIL reset_zero: got %b expected 0", bus.zero); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    int n_out;
    int first;
    n_out = 0;
    first = -1;
    for (int c = 0; c < 6 + NSEG + 4; c++) begin
      if (c < 6) drive(1'b1, dir_a[c], dir_b[c], dir_c[c], 1'b0, 1'b1);
      else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.out_valid !== mv[NSEG-1]) begin
        errors++; $display("FAIL directed_valid c=%0d: got %b expected %b", c, bus.out_valid, mv[NSEG-1]);
      end
      if (bus.out_valid === 1'b1) begin
        if (first < 0) first = c;
        if (n_out < 6) begin
          checks++;
          if (dut_res() !== dir_exp[n_out]) begin
            errors++; $display("FAIL directed_result[%0d]: got %h expected %h", n_out, dut_res(), dir_exp[n_out]);
          end
        end
        n_out++;
      end
      mdl_step();
      @(posedge clk); #1;
    end
    checks++; if (first != NSEG) begin errors++; $display("FAIL directed_latency: got %0d expected %0d", first, NSEG); end
    checks++; if (n_out != 6) begin errors++; $display("FAIL directed_count: got %0d expected 6", n_out); end
  endtask

`ifdef PIPE_ADDER_SUB_EN
  task automatic test_sub();
    logic [W-1:0] sa [2] = '{16'h0005, 16'h8000};
    logic [W-1:0] sb [2] = '{16'h0007, 16'h0001};
    res_t         se [2] = '{{16'hFFFE, 3'b000}, {16'h7FFF, 3'b110}};
    int n_out;
    n_out = 0;
    for (int c = 0; c < 2 + NSEG + 4; c++) begin
      if (c < 2) drive(1'b1, sa[c], sb[c], 1'b0, 1'b1, 1'b1);
      else       drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        if (n_out < 2) begin
          checks++;
          if (dut_res() !== se[n_out]) begin
            errors++; $display("FAIL sub_result[%0d]: got %h expected %h", n_out, dut_res(), se[n_out]);
          end
        end
        n_out++;
      end
      mdl_step();
      @(posedge clk); #1;
    end
    sub_drv = 1'b0;
    checks++; if (n_out != 2) begin errors++; $display("FAIL sub_count: got %0d expected 2", n_out); end
  endtask
`endif

  task automatic test_back_to_back();
    int   sent;
    int   got;
    logic exp_ir;
    sent = 0;
    got  = 0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      drive(sent < 8, 16'(sent), 16'(sent * 256), 1'b0, 1'b0, (c % 4 == 0) || (c % 4 == 3));
      @(negedge clk);
      exp_ir = !mv[NSEG-1] || bus.out_ready;
      checks++;
      if (bus.out_valid !== mv[NSEG-1]) begin
        errors++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, bus.out_valid, mv[NSEG-1]);
      end
      checks++;
      if (bus.in_ready !== exp_ir) begin
        errors++; $display("FAIL b2b_in_ready c=%0d: got %b expected %b", c, bus.in_ready, exp_ir);
      end
      if (mv[NSEG-1]) begin
        checks++;
        if (dut_res() !== mr[NSEG-1]) begin
          errors++; $display("FAIL b2b_hold c=%0d: got %h expected %h", c, dut_res(), mr[NSEG-1]);
        end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        checks++;
        if (bus.sum !== 16'(got * 257)) begin
          errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", got, bus.sum, 16'(got * 257));
        end
        got++;
      end
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) sent++;
      mdl_step();
      @(posedge clk); #1;
    end
    checks++; if (got != 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", got); end
  endtask

  task automatic test_reset_mid();
    int   first;
    res_t exp;
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 16'(16'h1111 * (c + 1)), 16'h0F0F, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      mdl_step();
      @(posedge clk); #1;
    end
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.sum !== 16'h0000) begin errors++; $display("FAIL rstmid_sum: got %h expected 0000", bus.sum); end
    mdl_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale c=%0d: got %b expected 0", c, bus.out_valid); end
      mdl_step();
      @(posedge clk); #1;
    end
    exp   = ref_result(16'h4321, 16'h1111, 1'b1, 1'b0);
    first = -1;
    for (int c = 0; c < NSEG + 6; c++) begin
      if (c == 0) drive(1'b1, 16'h4321, 16'h1111, 1'b1, 1'b0, 1'b1);
      else        drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      if (bus.out_valid === 1'b1 && first < 0) begin
        first = c;
        checks++;
        if (dut_res() !== exp) begin errors++; $display("FAIL rstmid_result: got %h expected %h", dut_res(), exp); end
      end
      mdl_step();
      @(posedge clk); #1;
    end
    checks++; if (first != NSEG) begin errors++; $display("FAIL rstmid_latency: got %0d expected %0d", first, NSEG); end
  endtask

  task automatic test_random();
    logic exp_ir;
    logic s;
    for (int c = 0; c < 400; c++) begin
      s = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
      s = 1'($urandom_range(0, 1));
`endif
      drive($urandom_range(0, 9) < 7, rnd_op(), rnd_op(), 1'($urandom_range(0, 1)), s,
            $urandom_range(0, 3) != 0);
      @(negedge clk);
      exp_ir = !mv[NSEG-1] || bus.out_ready;
      checks++;
      if (bus.out_valid !== mv[NSEG-1]) begin
        errors++; $display("FAIL rnd_valid c=%0d: got %b expected %b", c, bus.out_valid, mv[NSEG-1]);
      end
      checks++;
      if (bus.in_ready !== exp_ir) begin
        errors++; $display("FAIL rnd_in_ready c=%0d: got %b expected %b", c, bus.in_ready, exp_ir);
      end
      if (mv[NSEG-1]) begin
        checks++;
        if (dut_res() !== mr[NSEG-1]) begin
          errors++; $display("FAIL rnd_result c=%0d: got %h expected %h", c, dut_res(), mr[NSEG-1]);
        end
      end
      mdl_step();
      @(posedge clk); #1;
    end
    sub_drv = 1'b0;
  endtask

  initial begin
    sub_drv = 1'b0;
    test_reset();
    test_directed();
`ifdef PIPE_ADDER_SUB_EN
    test_sub();
`endif
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
